fetch_unit: RTL and testbench

//   Instruction fetch stage directly upstream of the decode control logic.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches,
// buffers responses and hands {pc, instr} to decode; redirects flush wrong-path.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [31:0]     dec_instr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW-1:0]   twr_q, twr_d, trd_q, trd_d;

  logic [XLEN-1:0] fpc_q  [FIFO_DEPTH];
  logic [31:0]     fins_q [FIFO_DEPTH];
  logic [XLEN-1:0] tag_q  [FIFO_DEPTH];

  logic        accept, resp, pop, push, discard;
  logic [CW:0] credit;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // A same-cycle pop is deliberately not credited back.
  assign credit = {1'b0, cnt_q} + {1'b0, out_q};

  assign imem_req_valid = rst_n && (state_q == RUN) &&
                          !redirect_valid && (credit < DEPTH_C);
  assign imem_req_addr  = pc_q;

  assign accept    = imem_req_valid && imem_req_ready;
  assign resp      = imem_resp_valid;
  assign dec_valid = (cnt_q != '0);
  assign pop       = dec_valid && dec_ready;
  assign discard   = redirect_valid || (state_q == DRAIN);
  assign push      = resp && !discard;
  assign dec_pc    = fpc_q[rd_q];
  assign dec_instr = fins_q[rd_q];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    out_d   = out_q + CW'(accept) - CW'(resp);
    drop_d  = drop_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    twr_d   = twr_q;
    trd_d   = trd_q;
    if (accept) begin
      pc_d  = pc_q + XLEN'(4);
      twr_d = twr_q + AW'(1);
    end
    if (resp) trd_d = trd_q + AW'(1);
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    if (redirect_valid) begin
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      drop_d  = out_q - CW'(resp);
      state_d = (drop_d != '0) ? DRAIN : RUN;
    end else if (state_q == DRAIN && resp) begin
      drop_d = drop_q - CW'(1);
      if (drop_q == CW'(1)) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      out_q   <= '0;
      drop_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      twr_q   <= '0;
      trd_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fpc_q[i]  <= '0;
        fins_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      twr_q   <= twr_d;
      trd_q   <= trd_d;
      if (accept) tag_q[twr_q] <= pc_q;
      if (push) begin
        fpc_q[wr_q]  <= tag_q[trd_q];
        fins_q[wr_q] <= imem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency memory model.
// Memory returns ~addr so every delivered instr can be tied to its pc.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_pc          (dec_pc),
    .dec_instr       (dec_instr)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc;
  int lat;
  logic mem_rdy;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];
  int acc_first, dv_first;

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    got_pc.delete();
    got_in.delete();
    acc_first = -1;
    dv_first  = -1;
  endtask

  // One clock cycle; called just after a falling edge.
  task automatic step();
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = ~mq_addr[0];
      mq_due.delete(0);
      mq_addr.delete(0);
    end
    imem_req_ready = mem_rdy;
    #1;
    if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
      req_log.push_back(imem_req_addr);
      req_cyc.push_back(cyc);
      if (acc_first < 0) acc_first = cyc;
    end
    if (dec_valid && dv_first < 0) dv_first = cyc;
    if (dec_valid && dec_ready) begin
      got_pc.push_back(dec_pc);
      got_in.push_back(dec_instr);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_resp_valid = 1'b0;
    dec_ready       = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    clear_logs();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vecs++;
    if (imem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
    end
    vecs++;
    if (imem_req_addr !== 32'h0) begin
      errs++;
      $display("FAIL reset_req_addr: got %h want 0", imem_req_addr);
    end
    vecs++;
    if ({dec_valid, dec_pc, dec_instr} !== 65'h0) begin
      errs++;
      $display("FAIL reset_dec: got %b %h %h want 0",
               dec_valid, dec_pc, dec_instr);
    end
    rst_n = 1'b1;
    cyc   = 0;
    clear_logs();
  endtask

  task automatic test_stream();
    int bad;
    lat = 1; mem_rdy = 1'b1; dec_ready = 1'b1;
    run(12);
    vecs++;
    if (dv_first - acc_first !== 2) begin
      errs++;
      $display("FAIL stream_latency: got %0d want 2", dv_first - acc_first);
    end
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (req_log.size() <= i || req_log[i] !== 32'(4*i)) bad++;
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL stream_req_addr: got %0d bad want 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (got_pc.size() <= i || got_pc[i] !== 32'(4*i) ||
          got_in[i] !== ~32'(4*i)) bad++;
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL stream_dec_seq: got %0d bad want 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    vecs++;
    if (dec_valid !== 1'b1) begin
      errs++;
      $display("FAIL midrst_pre: got %b want 1", dec_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({imem_req_valid, dec_valid, imem_req_addr} !== 34'h0) begin
      errs++;
      $display("FAIL midrst_async: got %b %b %h want 0 0 0",
               imem_req_valid, dec_valid, imem_req_addr);
    end
    apply_reset();
  endtask

  task automatic test_backpressure();
    int bad;
    lat = 1; mem_rdy = 1'b1; dec_ready = 1'b0;
    run(10);
    vecs++;
    if (req_log.size() !== 4) begin
      errs++;
      $display("FAIL bp_req_count: got %0d want 4", req_log.size());
    end
    vecs++;
    if ({imem_req_valid, dec_valid, dec_pc, dec_instr} !==
        {1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF}) begin
      errs++;
      $display("FAIL bp_hold: got %b %b %h %h want 0 1 0 ffffffff",
               imem_req_valid, dec_valid, dec_pc, dec_instr);
    end
    dec_ready = 1'b1;
    run(14);
    bad = 0;
    if (got_pc.size() < 8) bad++;
    for (int i = 0; i < got_pc.size(); i++)
      if (got_pc[i] !== 32'(4*i) || got_in[i] !== ~32'(4*i)) bad++;
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL bp_resume_seq: got %0d bad (n=%0d) want 0",
               bad, got_pc.size());
    end
  endtask

  task automatic test_redirect_drain();
    int bad;
    apply_reset();
    lat = 4; mem_rdy = 1'b1; dec_ready = 1'b1;
    run(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    run(11);
    vecs++;
    if (req_log.size() < 4 || req_log[3] !== 32'h100 ||
        req_cyc[3] !== 7) begin
      errs++;
      $display("FAIL drain_restart: got n=%0d addr %h cyc %0d want 100 @7",
               req_log.size(), req_log.size() > 3 ? req_log[3] : 32'h0,
               req_cyc.size() > 3 ? req_cyc[3] : -1);
    end
    bad = 0;
    for (int i = 0; i < got_pc.size(); i++)
      if (got_pc[i] < 32'h100) bad++;
    vecs++;
    if (bad !== 0 || got_pc.size() < 1 || got_pc[0] !== 32'h100) begin
      errs++;
      $display("FAIL drain_wrong_path: got %0d stale, n=%0d want 0 stale",
               bad, got_pc.size());
    end
  endtask

  task automatic test_redirect_coincident();
    apply_reset();
    lat = 1; mem_rdy = 1'b1; dec_ready = 1'b1;
    run(4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    #1;
    vecs++;
    if ({dec_valid, imem_req_valid, imem_req_addr} !==
        {1'b0, 1'b1, 32'h40}) begin
      errs++;
      $display("FAIL coinc_next: got %b %b %h want 0 1 00000040",
               dec_valid, imem_req_valid, imem_req_addr);
    end
    vecs++;
    if (got_pc.size() !== 3 || got_pc[2] !== 32'h8) begin
      errs++;
      $display("FAIL coinc_pop_once: got n=%0d want 3 ending 8",
               got_pc.size());
    end
    run(4);
    vecs++;
    if (got_pc.size() < 4 || got_pc[3] !== 32'h40) begin
      errs++;
      $display("FAIL coinc_resume: got n=%0d want pc 40 after 8",
               got_pc.size());
    end
  endtask

  task automatic test_double_redirect();
    int bad;
    apply_reset();
    lat = 4; mem_rdy = 1'b1; dec_ready = 1'b1;
    run(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    run(8);
    bad = 0;
    for (int i = 0; i < req_log.size(); i++)
      if (req_log[i] >= 32'h100 && req_log[i] < 32'h200) bad++;
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL dbl_no_100_path: got %0d reqs want 0", bad);
    end
    vecs++;
    if (req_log.size() < 4 || req_log[3] !== 32'h200 ||
        req_cyc[3] !== 7) begin
      errs++;
      $display("FAIL dbl_restart: got n=%0d want 200 @7", req_log.size());
    end
    vecs++;
    if (got_pc.size() < 1 || got_pc[0] !== 32'h200) begin
      errs++;
      $display("FAIL dbl_first_dec: got n=%0d want first pc 200",
               got_pc.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    lat = 1; mem_rdy = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    run(5);
    vecs++;
    if (req_log.size() < 3 || req_log[0] !== 32'hFFFF_FFFC ||
        req_log[1] !== 32'h0 || req_log[2] !== 32'h4) begin
      errs++;
      $display("FAIL wrap_req: got n=%0d want fffffffc,0,4", req_log.size());
    end
    vecs++;
    if (got_pc.size() < 2 || got_pc[0] !== 32'hFFFF_FFFC ||
        got_in[0] !== 32'h3 || got_pc[1] !== 32'h0) begin
      errs++;
      $display("FAIL wrap_dec: got n=%0d want fffffffc/3 then 0",
               got_pc.size());
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    dec_ready       = 1'b0;
    mem_rdy         = 1'b0;
    lat             = 1;
    cyc             = 0;
    clear_logs();
    test_reset();
    test_stream();
    test_mid_reset();
    test_backpressure();
    test_redirect_drain();
    test_redirect_coincident();
    test_double_redirect();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
